uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, number of requesters sharing one UART transmitter (range 2..8).
REQ-002 The block SHALL have parameter TIMEOUT, default 4096, number of clk cycles LAUNCH may wait for tx_busy before abandoning.
REQ-003 The block SHALL have port clk, input, 1, system clock, all logic rising-edge.
REQ-004 The block SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-005 The block SHALL have port req_valid, input, NUM_REQ, per-requester byte-pending flag.
REQ-006 The block SHALL have port req_data, input, 8*NUM_REQ, requester i byte at bits [8i+7:8i].
REQ-007 The block SHALL have port req_ready, output, NUM_REQ, one-cycle pulse meaning the byte is captured.
REQ-008 The block SHALL have port tx_start, output, 1, start request to the transmitter.
REQ-009 The block SHALL have port tx_data, output, 8, byte presented to the transmitter.
REQ-010 The block SHALL have port tx_busy, input, 1, transmitter busy, asynchronous to clk (baud_tick domain).
REQ-011 The block SHALL have port grant_id, output, clog2(NUM_REQ), index of the current or last granted requester.
REQ-012 The block SHALL have port active, output, 1, high in every state except IDLE.
REQ-013 The block SHALL have port timeout_err, output, 1, one-cycle pulse on abandoned launch (present only with UART_ARB_TIMEOUT_EN).

Function
REQ-014 tx_busy SHALL pass through a 2-flop synchronizer; "busy_s" below is the synchronized value.
REQ-015 The FSM SHALL have states IDLE, LAUNCH and SEND.
REQ-016 In IDLE, on a clk edge with any req_valid bit high, the FSM SHALL select winner w by round-robin, searching from (last_grant+1) mod NUM_REQ upward with wrap.
REQ-017 On that same edge the block SHALL load tx_data with req_data[w], set grant_id=w, register req_ready[w]=1 for exactly one cycle, set tx_start=1, and enter LAUNCH.
REQ-018 In LAUNCH, tx_start SHALL stay 1 until busy_s=1 is sampled; on that edge tx_start SHALL go 0 and the FSM SHALL enter SEND.
REQ-019 In SEND, on busy_s=0 the FSM SHALL set last_grant=w and enter IDLE.
REQ-020 tx_data SHALL remain stable from capture until the return to IDLE, because the transmitter reads data bits live during the frame.
REQ-021 Requesters SHALL be free to change req_data or drop req_valid after their req_ready pulse; a requester that drops req_valid before being granted SHALL NOT be granted.
REQ-022 IDLE SHALL last at least one cycle between grants; the worst-case wait for any persistently valid requester SHALL be NUM_REQ-1 frames.
REQ-023 If all req_valid bits are 0 in IDLE, the block SHALL hold all outputs and last_grant.
REQ-024 A busy_s value already 1 on entry to LAUNCH SHALL be accepted as the start acknowledgement.

Reset
REQ-025 While rst=1: state=IDLE, tx_start=0, tx_data=0, req_ready=0, grant_id=0, active=0, timeout_err=0, last_grant=NUM_REQ-1 (so requester 0 wins first), synchronizer flops=0.
REQ-026 Reset mid-LAUNCH or mid-SEND SHALL abandon the byte without a further req_ready pulse; the transmitter is reset separately.

Configuration
REQ-027 With UART_ARB_TIMEOUT_EN defined, a counter SHALL run in LAUNCH; if TIMEOUT cycles elapse without busy_s=1, the block SHALL drop tx_start, pulse timeout_err for one cycle, set last_grant=w, and enter IDLE.
REQ-028 Without UART_ARB_TIMEOUT_EN, the timeout_err port and counter SHALL be absent, and LAUNCH SHALL wait indefinitely.

Verification
REQ-029 Bench: reset, req_valid=0001 with data 0x55 -> req_ready[0] one pulse, tx_data=0x55, tx_start high until busy_s, the line frame carries 0x55 LSB-first, and active returns to 0.
REQ-030 Bench: all four valid with data 0xA0..0xA3 held -> grants in order 0,1,2,3,0, each byte sent once per grant.
REQ-031 Bench: requester 2 changes req_data immediately after its req_ready -> the transmitted byte equals the captured value.
REQ-032 Bench: assert rst during SEND of 0x3C -> all outputs reach reset values immediately, and the next grant goes to requester 0.
REQ-033 Bench: UART_ARB_TIMEOUT_EN with TIMEOUT=16 and tx_busy tied 0 -> timeout_err pulses 16 cycles after LAUNCH entry and the FSM returns to IDLE; without the macro, tx_start stays 1.
REQ-034 Bench: req_valid[1] pulses one cycle while requester 0 is in SEND -> requester 1 is never granted.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding NUM_REQ byte requesters into one UART transmitter.
// Optional LAUNCH timeout and timeout_err port enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx_start,
    output logic [7:0]                 tx_data,
    input  logic                       tx_busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       active
`ifdef UART_ARB_TIMEOUT_EN
    ,
    output logic                       timeout_err
`endif
);

    localparam int GW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_SEND} state_t;

    state_t             r_state, w_state_nxt;
    logic               r_busy_meta, r_busy_s;
    logic               r_tx_start, w_tx_start_nxt;
    logic [7:0]         r_tx_data, w_tx_data_nxt;
    logic [NUM_REQ-1:0] r_req_ready, w_req_ready_nxt;
    logic [GW-1:0]      r_grant_id, w_grant_id_nxt;
    logic [GW-1:0]      r_last_grant, w_last_grant_nxt;
    logic [GW-1:0]      w_win, w_cand;
    logic [7:0]         w_bytes [NUM_REQ];
    int                 w_sum;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] r_to_cnt, w_to_cnt_nxt;
    logic          r_timeout_err, w_timeout_err_nxt;
    assign timeout_err = r_timeout_err;
`endif

    assign req_ready = r_req_ready;
    assign tx_start  = r_tx_start;
    assign tx_data   = r_tx_data;
    assign grant_id  = r_grant_id;
    assign active    = (r_state != S_IDLE);

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) w_bytes[i] = req_data[8*i +: 8];
    end

    // Walk offsets high to low so the nearest valid requester after last_grant wins.
    always_comb begin
        w_win  = '0;
        w_cand = '0;
        w_sum  = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_sum = int'(r_last_grant) + k;
            if (w_sum >= NUM_REQ) w_sum = w_sum - NUM_REQ;
            w_cand = GW'(w_sum);
            if (req_valid[w_cand]) w_win = w_cand;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_tx_start_nxt   = r_tx_start;
        w_tx_data_nxt    = r_tx_data;
        w_req_ready_nxt  = '0;
        w_grant_id_nxt   = r_grant_id;
        w_last_grant_nxt = r_last_grant;
`ifdef UART_ARB_TIMEOUT_EN
        w_to_cnt_nxt      = '0;
        w_timeout_err_nxt = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (|req_valid) begin
                    w_tx_data_nxt          = w_bytes[w_win];
                    w_grant_id_nxt         = w_win;
                    w_req_ready_nxt[w_win] = 1'b1;
                    w_tx_start_nxt         = 1'b1;
                    w_state_nxt            = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (r_busy_s) begin
                    w_tx_start_nxt = 1'b0;
                    w_state_nxt    = S_SEND;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (r_to_cnt == CW'(TIMEOUT - 1)) begin
                    w_tx_start_nxt    = 1'b0;
                    w_timeout_err_nxt = 1'b1;
                    w_last_grant_nxt  = r_grant_id;
                    w_state_nxt       = S_IDLE;
                end else begin
                    w_to_cnt_nxt = r_to_cnt + 1'b1;
                end
`endif
            end
            S_SEND: begin
                if (!r_busy_s) begin
                    w_last_grant_nxt = r_grant_id;
                    w_state_nxt      = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // last_grant resets to the top index so requester 0 is searched first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_busy_meta  <= 1'b0;
            r_busy_s     <= 1'b0;
            r_tx_start   <= 1'b0;
            r_tx_data    <= '0;
            r_req_ready  <= '0;
            r_grant_id   <= '0;
            r_last_grant <= GW'(NUM_REQ - 1);
`ifdef UART_ARB_TIMEOUT_EN
            r_to_cnt      <= '0;
            r_timeout_err <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_busy_meta  <= tx_busy;
            r_busy_s     <= r_busy_meta;
            r_tx_start   <= w_tx_start_nxt;
            r_tx_data    <= w_tx_data_nxt;
            r_req_ready  <= w_req_ready_nxt;
            r_grant_id   <= w_grant_id_nxt;
            r_last_grant <= w_last_grant_nxt;
`ifdef UART_ARB_TIMEOUT_EN
            r_to_cnt      <= w_to_cnt_nxt;
            r_timeout_err <= w_timeout_err_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a simple UART transmitter model.
// Build with UART_ARB_TIMEOUT_EN defined to exercise the launch timeout.
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int BIT  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic [1:0]  grant_id;
    logic        active;
`ifdef UART_ARB_TIMEOUT_EN
    logic        timeout_err;
`endif

    uart_tx_arbiter #(.NUM_REQ(NREQ), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data),
        .tx_busy(tx_busy), .grant_id(grant_id), .active(active)
`ifdef UART_ARB_TIMEOUT_EN
        , .timeout_err(timeout_err)
`endif
    );

    always #5 clk = ~clk;

    int         n_chk  = 0;
    int         n_fail = 0;
    int         exp_gnt[$];
    logic [7:0] exp_gdat[$];
    logic [7:0] exp_byte[$];

    logic       busy_en;
    logic       line;
    int         m_cnt;
    logic [7:0] m_got;
    int         mg;
    logic [7:0] md;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input int g, input logic [7:0] d, input bit framed);
        exp_gnt.push_back(g);
        exp_gdat.push_back(d);
        if (framed) exp_byte.push_back(d);
    endtask

    // Grant monitor: every req_ready pulse must match the next expected grant.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && |req_ready) begin
                if (exp_gnt.size() == 0) begin
                    chk("unexpected_grant", 32'(req_ready), 0);
                end else begin
                    mg = exp_gnt.pop_front();
                    md = exp_gdat.pop_front();
                    chk("req_ready", 32'(req_ready), 32'(1 << mg));
                    chk("grant_id", 32'(grant_id), 32'(mg));
                    chk("tx_data_capture", 32'(tx_data), 32'(md));
                    chk("tx_start_on_grant", 32'(tx_start), 1);
                end
            end
        end
    end

    // Transmitter model: busy 3 cycles after start, 10-bit frame reading tx_data live.
    initial begin
        tx_busy = 1'b0;
        line    = 1'b1;
        m_cnt   = 0;
        m_got   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_cnt   = 0;
                tx_busy = 1'b0;
                line    = 1'b1;
            end else if (m_cnt == 0) begin
                if (busy_en && tx_start) m_cnt = 1;
            end else begin
                m_cnt++;
                if (m_cnt == 3) begin
                    chk("tx_start_held", 32'(tx_start), 1);
                    tx_busy = 1'b1;
                end
                if (m_cnt == 3 + BIT) chk("tx_start_dropped", 32'(tx_start), 0);
                if (m_cnt >= 3 && m_cnt < 3 + 10*BIT) begin
                    if ((m_cnt - 3) % BIT == 0) begin
                        if ((m_cnt - 3) / BIT == 0)      line = 1'b0;
                        else if ((m_cnt - 3) / BIT == 9) line = 1'b1;
                        else                             line = tx_data[(m_cnt - 3) / BIT - 1];
                    end
                    if ((m_cnt - 3) % BIT == BIT/2 && (m_cnt - 3) / BIT >= 1 && (m_cnt - 3) / BIT <= 8)
                        m_got[(m_cnt - 3) / BIT - 1] = line;
                end
                if (m_cnt == 3 + 10*BIT) begin
                    tx_busy = 1'b0;
                    m_cnt   = 0;
                    if (exp_byte.size() == 0) chk("unexpected_frame", 32'(m_got), 0);
                    else                      chk("frame_byte", 32'(m_got), 32'(exp_byte.pop_front()));
                end
            end
        end
    end

    task automatic wait_ready(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (|req_ready) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk({name, "_ready_timeout"}, 0, 1);
    endtask

    task automatic wait_idle(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (!active && m_cnt == 0 && !tx_busy) begin
                seen = 1'b1;
                break;
            end
        end
        if (seen) chk({name, "_active_idle"}, 32'(active), 0);
        else      chk({name, "_idle_timeout"}, 0, 1);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        busy_en   = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_tx_start", 32'(tx_start), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_grant_id", 32'(grant_id), 0);
        chk("rst_active", 32'(active), 0);
`ifdef UART_ARB_TIMEOUT_EN
        chk("rst_timeout_err", 32'(timeout_err), 0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // Single requester, 0x55.
        req_data[7:0] = 8'h55;
        push(0, 8'h55, 1'b1);
        req_valid = 4'b0001;
        wait_ready("single");
        req_valid = '0;
        wait_idle("single");

        // All four valid after reset: 0,1,2,3,0.
        do_reset();
        req_data = 32'hA3A2A1A0;
        for (int i = 0; i < 5; i++) push(i % 4, 8'hA0 + 8'(i % 4), 1'b1);
        req_valid = 4'hF;
        for (int i = 0; i < 5; i++) wait_ready("rr");
        req_valid = '0;
        wait_idle("rr");

        // Requester 2 changes data right after capture.
        req_data[23:16] = 8'h6B;
        push(2, 8'h6B, 1'b1);
        req_valid = 4'b0100;
        wait_ready("late_data");
        req_data[23:16] = 8'hFF;
        req_valid = '0;
        wait_idle("late_data");

        // One-cycle valid from requester 1 while requester 0 is in SEND.
        req_data[7:0] = 8'h11;
        push(0, 8'h11, 1'b1);
        req_valid = 4'b0001;
        wait_ready("glitch");
        req_valid = '0;
        repeat (15) @(negedge clk);
        chk("glitch_in_send", 32'(active), 1);
        req_valid = 4'b0010;
        @(negedge clk);
        req_valid = '0;
        wait_idle("glitch");
        repeat (5) @(negedge clk);

        // Reset during SEND of 0x3C, then requester 0 wins first.
        req_data[15:8] = 8'h3C;
        push(1, 8'h3C, 1'b0);
        req_valid = 4'b0010;
        wait_ready("mid_rst");
        req_valid = '0;
        repeat (15) @(negedge clk);
        chk("mid_rst_active_before", 32'(active), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_tx_start", 32'(tx_start), 0);
        chk("mid_rst_tx_data", 32'(tx_data), 0);
        chk("mid_rst_req_ready", 32'(req_ready), 0);
        chk("mid_rst_grant_id", 32'(grant_id), 0);
        chk("mid_rst_active", 32'(active), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        req_data[7:0] = 8'h77;
        push(0, 8'h77, 1'b1);
        req_valid = 4'b0011;
        wait_ready("post_rst");
        req_valid = '0;
        wait_idle("post_rst");

        // Transmitter never acknowledges.
        busy_en = 1'b0;
        req_data[31:24] = 8'h99;
        push(3, 8'h99, 1'b0);
        req_valid = 4'b1000;
        wait_ready("no_ack");
        req_valid = '0;
`ifdef UART_ARB_TIMEOUT_EN
        begin
            int k;
            k = 0;
            for (int i = 1; i <= 40; i++) begin
                @(negedge clk);
                if (timeout_err) begin
                    k = i;
                    break;
                end
            end
            chk("timeout_cycles", 32'(k), 16);
            chk("timeout_active", 32'(active), 0);
            chk("timeout_tx_start", 32'(tx_start), 0);
            @(negedge clk);
            chk("timeout_pulse_width", 32'(timeout_err), 0);
        end
`else
        repeat (40) @(negedge clk);
        chk("launch_hold_tx_start", 32'(tx_start), 1);
        chk("launch_hold_active", 32'(active), 1);
        do_reset();
`endif
        busy_en = 1'b1;
        repeat (5) @(negedge clk);

        chk("grant_queue_drained", 32'(exp_gnt.size()), 0);
        chk("byte_queue_drained", 32'(exp_byte.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
